// File: rtl/prealu_queue_if.sv
// prealu_queue_if: operand buses, staging strobes and ALU-side handshake of the operand stager
interface prealu_queue_if #(parameter int WIDTH = 8, parameter int DEPTH = 2);
  logic [WIDTH-1:0] db, adl, sb;
  logic dbwa, dbinva, adlwa, sbwa, ldzero, push, alu_ready;
  logic [WIDTH-1:0] aOut, bOut;
  logic op_valid, full, err;
  logic [$clog2(DEPTH):0] count;
  modport master(output db, adl, sb, dbwa, dbinva, adlwa, sbwa, ldzero, push, alu_ready,
                 input aOut, bOut, op_valid, full, err, count);
  modport slave(input db, adl, sb, dbwa, dbinva, adlwa, sbwa, ldzero, push, alu_ready,
                output aOut, bOut, op_valid, full, err, count);
endinterface

// File: rtl/prealu_queue.sv
// prealu_queue: stages ALU operand pairs and queues complete pairs in a DEPTH-entry FIFO
module prealu_queue #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input logic clk,
  input logic reset,
  prealu_queue_if.slave q
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] ONE = 1;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  logic [WIDTH-1:0] a_stg, b_stg;
  logic a_ld, b_ld;
  logic [WIDTH-1:0] mem_a [DEPTH];
  logic [WIDTH-1:0] mem_b [DEPTH];
  logic [AW:0] head, tail, count;
  logic pop, accept, a_wr, b_wr;
  assign count = tail - head;
  assign q.count = count;
  assign q.full = count == FULL_CNT;
  assign q.op_valid = count != '0;
  assign q.aOut = q.op_valid ? mem_a[head[AW-1:0]] : '0;
  assign q.bOut = q.op_valid ? mem_b[head[AW-1:0]] : '0;
  assign pop = q.alu_ready & q.op_valid;
  assign accept = q.push & a_ld & b_ld & (!q.full | pop);
  assign a_wr = q.ldzero | q.sbwa;
  assign b_wr = q.dbwa | q.dbinva | q.adlwa;
  // a write in the same cycle as an accepted push starts the next pair
  always_ff @(posedge clk) begin
    if (reset) begin
      a_stg <= '0;
      b_stg <= '0;
      a_ld <= 1'b0;
      b_ld <= 1'b0;
      head <= '0;
      tail <= '0;
      q.err <= 1'b0;
    end else begin
      if (a_wr) a_stg <= q.ldzero ? '0 : q.sb;
      if (b_wr) b_stg <= q.dbwa ? q.db : q.dbinva ? ~q.db : q.adl;
      a_ld <= a_wr | (a_ld & !accept);
      b_ld <= b_wr | (b_ld & !accept);
      if (accept) begin
        mem_a[tail[AW-1:0]] <= a_stg;
        mem_b[tail[AW-1:0]] <= b_stg;
        tail <= tail + ONE;
      end
      if (pop) head <= head + ONE;
      if (q.push & !accept) q.err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_prealu_queue.sv
// tb_prealu_queue: directed vector table plus randomized run against a queue-based model
module tb_prealu_queue;
  localparam int W = 8;
  localparam int D = 2;
  localparam logic [6:0] SB = 7'b1000000, LZ = 7'b0100000, DW = 7'b0010000, DI = 7'b0001000,
                         AL = 7'b0000100, PU = 7'b0000010, AR = 7'b0000001, NO = 7'b0000000;
  typedef struct {
    logic rst;
    logic [6:0] ctl;
    logic [W-1:0] sb, db, adl, ea, eb;
    logic ev, ef, ee;
    logic [1:0] ec;
  } vec_t;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int errors = 0, checks = 0;
  logic [W-1:0] m_a, m_b;
  logic m_ald, m_bld, m_err;
  logic [2*W-1:0] mq[$];
  vec_t tbl[$];
  prealu_queue_if #(.WIDTH(W), .DEPTH(D)) bus ();
  prealu_queue #(.WIDTH(W), .DEPTH(D)) dut (.clk(clk), .reset(reset), .q(bus));
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic r, input logic [6:0] c, input logic [W-1:0] s, d, l, a, b,
                              input logic v, input logic [1:0] n, input logic f, e);
    vec_t t;
    t.rst = r; t.ctl = c; t.sb = s; t.db = d; t.adl = l; t.ea = a; t.eb = b;
    t.ev = v; t.ec = n; t.ef = f; t.ee = e;
    return t;
  endfunction

  function automatic logic [2*W+4:0] got();
    return {bus.aOut, bus.bOut, bus.op_valid, bus.count, bus.full, bus.err};
  endfunction

  function automatic logic [2*W+4:0] model_out();
    logic [2*W-1:0] h;
    h = mq.size() > 0 ? mq[0] : '0;
    return {h, mq.size() > 0, 2'(mq.size()), mq.size() == D, m_err};
  endfunction

  task automatic model_step(input logic r, input logic [6:0] c, input logic [W-1:0] s, d, l);
    logic pop, acc;
    if (r) begin
      m_a = '0; m_b = '0; m_ald = 0; m_bld = 0; m_err = 0; mq.delete();
      return;
    end
    pop = c[0] && mq.size() > 0;
    acc = c[1] && m_ald && m_bld && (mq.size() < D || pop);
    if (c[1] && !acc) m_err = 1;
    if (pop) void'(mq.pop_front());
    if (acc) mq.push_back({m_a, m_b});
    if (c & LZ) m_a = '0;
    else if (c & SB) m_a = s;
    if (c & DW) m_b = d;
    else if (c & DI) m_b = ~d;
    else if (c & AL) m_b = l;
    m_ald = |(c & (LZ | SB)) || (m_ald && !acc);
    m_bld = |(c & (DW | DI | AL)) || (m_bld && !acc);
  endtask

  task automatic cyc(input logic r, input logic [6:0] c, input logic [W-1:0] s, d, l);
    reset = r;
    {bus.sbwa, bus.ldzero, bus.dbwa, bus.dbinva, bus.adlwa, bus.push, bus.alu_ready} = c;
    bus.sb = s; bus.db = d; bus.adl = l;
    model_step(r, c, s, d, l);
    @(posedge clk);
    #1;
    checks++;
    if (got() !== model_out()) begin
      errors++;
      $display("FAIL model t=%0t got a/b/v/cnt/f/e=%h required %h", $time, got(), model_out());
    end
  endtask

  initial begin
    logic [6:0] c;
    tbl.push_back(mk(1, NO, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0));
    tbl.push_back(mk(0, SB, 8'h12, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0));
    tbl.push_back(mk(0, DW, 0, 8'h34, 0, 8'h00, 8'h00, 0, 0, 0, 0));
    tbl.push_back(mk(0, PU, 0, 0, 0, 8'h12, 8'h34, 1, 1, 0, 0));
    tbl.push_back(mk(0, AR, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0));
    tbl.push_back(mk(0, LZ|SB|DI, 8'hFF, 8'h0F, 0, 8'h00, 8'h00, 0, 0, 0, 0));
    tbl.push_back(mk(0, PU, 0, 0, 0, 8'h00, 8'hF0, 1, 1, 0, 0));
    tbl.push_back(mk(0, AR, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0));
    tbl.push_back(mk(0, SB|DW|AL, 8'h01, 8'h5A, 8'hC3, 8'h00, 8'h00, 0, 0, 0, 0));
    tbl.push_back(mk(0, PU, 0, 0, 0, 8'h01, 8'h5A, 1, 1, 0, 0));
    tbl.push_back(mk(0, AR, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0));
    tbl.push_back(mk(0, SB|DW, 8'h11, 8'h22, 0, 8'h00, 8'h00, 0, 0, 0, 0));
    tbl.push_back(mk(0, PU, 0, 0, 0, 8'h11, 8'h22, 1, 1, 0, 0));
    tbl.push_back(mk(0, SB|DW, 8'h33, 8'h44, 0, 8'h11, 8'h22, 1, 1, 0, 0));
    tbl.push_back(mk(0, PU, 0, 0, 0, 8'h11, 8'h22, 1, 2, 1, 0));
    tbl.push_back(mk(0, SB|DW, 8'h55, 8'h66, 0, 8'h11, 8'h22, 1, 2, 1, 0));
    tbl.push_back(mk(0, PU, 0, 0, 0, 8'h11, 8'h22, 1, 2, 1, 1));
    tbl.push_back(mk(1, NO, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0));
    tbl.push_back(mk(0, SB|DW, 8'h11, 8'h22, 0, 8'h00, 8'h00, 0, 0, 0, 0));
    tbl.push_back(mk(0, PU|SB|DW, 8'h33, 8'h44, 0, 8'h11, 8'h22, 1, 1, 0, 0));
    tbl.push_back(mk(0, PU|SB|DW, 8'h55, 8'h66, 0, 8'h11, 8'h22, 1, 2, 1, 0));
    tbl.push_back(mk(0, PU|AR, 0, 0, 0, 8'h33, 8'h44, 1, 2, 1, 0));
    tbl.push_back(mk(0, AR, 0, 0, 0, 8'h55, 8'h66, 1, 1, 0, 0));
    tbl.push_back(mk(0, AR, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0));
    tbl.push_back(mk(0, AR, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0));
    tbl.push_back(mk(0, SB, 8'hAA, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0));
    tbl.push_back(mk(0, PU, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 1));
    tbl.push_back(mk(0, AL, 0, 0, 8'hBB, 8'h00, 8'h00, 0, 0, 0, 1));
    tbl.push_back(mk(0, PU, 0, 0, 0, 8'hAA, 8'hBB, 1, 1, 0, 1));
    tbl.push_back(mk(0, SB|DW, 8'h01, 8'h02, 0, 8'hAA, 8'hBB, 1, 1, 0, 1));
    tbl.push_back(mk(0, PU|SB, 8'h77, 0, 0, 8'hAA, 8'hBB, 1, 2, 1, 1));
    tbl.push_back(mk(0, AR, 0, 0, 0, 8'h01, 8'h02, 1, 1, 0, 1));
    tbl.push_back(mk(0, DW, 0, 8'h88, 0, 8'h01, 8'h02, 1, 1, 0, 1));
    tbl.push_back(mk(0, PU, 0, 0, 0, 8'h01, 8'h02, 1, 2, 1, 1));
    tbl.push_back(mk(0, AR, 0, 0, 0, 8'h77, 8'h88, 1, 1, 0, 1));
    tbl.push_back(mk(1, PU|AR, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0));
    {bus.sbwa, bus.ldzero, bus.dbwa, bus.dbinva, bus.adlwa, bus.push, bus.alu_ready} = '0;
    bus.sb = '0; bus.db = '0; bus.adl = '0;
    foreach (tbl[i]) begin
      cyc(tbl[i].rst, tbl[i].ctl, tbl[i].sb, tbl[i].db, tbl[i].adl);
      checks++;
      if (got() !== {tbl[i].ea, tbl[i].eb, tbl[i].ev, tbl[i].ec, tbl[i].ef, tbl[i].ee}) begin
        errors++;
        $display("FAIL vec%0d got a/b/v/cnt/f/e=%h required %h", i, got(),
                 {tbl[i].ea, tbl[i].eb, tbl[i].ev, tbl[i].ec, tbl[i].ef, tbl[i].ee});
      end
    end
    for (int i = 0; i < 3000; i++) begin
      c = 7'($urandom);
      if ($urandom_range(3) != 0) c[6:2] = c[6:2] & 5'($urandom);
      cyc($urandom_range(99) == 0, c, 8'($urandom), 8'($urandom), 8'($urandom));
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
